fir_tap_sequencer: RTL and testbench

//  Compute stage of the adaptive FIR. Accepts one signed sample per handshake and writes it into the circular X sample RAM.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_mac.sv | 58 +++++
 rtl/fir_tap_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the adaptive FIR compute stage.
package fir_pkg;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Widths for the default build (8-bit data, 8 taps).
    localparam int ACC_W = 2 * 8 + clogb2(8);
    localparam int OUT_W = 16;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        READ,
        DRAIN,
        OUT
    } seq_state_t;

endpackage

// File: rtl/fir_mac.sv
// Read-valid pipe matching the RAM latency, plus signed multiply-accumulate.
module fir_mac
    import fir_pkg::*;
#(
    parameter int RAM_WIDTH = 8,
    parameter int RD_LAT    = 2,
    parameter int ACC_W     = 19
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        issue,
    input  logic [RAM_WIDTH-1:0]        x_data,
    input  logic [RAM_WIDTH-1:0]        h_data,
    output logic signed [ACC_W-1:0]     acc_next,
    output logic                        pending
);

    logic [RD_LAT-1:0]                vld_p;
    logic signed [ACC_W-1:0]          acc;
    logic signed [2*RAM_WIDTH-1:0]    x_ext;
    logic signed [2*RAM_WIDTH-1:0]    h_ext;
    logic signed [2*RAM_WIDTH-1:0]    prod;

    assign x_ext = (2*RAM_WIDTH)'($signed(x_data));
    assign h_ext = (2*RAM_WIDTH)'($signed(h_data));
    assign prod  = x_ext * h_ext;

    always_comb begin
        acc_next = acc;
        if (clr)
            acc_next = '0;
        else if (vld_p[RD_LAT-1])
            acc_next = acc + ACC_W'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            acc   <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LAT; i++)
                vld_p[i] <= vld_p[i-1];
            acc <= acc_next;
        end
    end

    // Reads still in flight other than the one landing this cycle.
    generate
        if (RD_LAT > 1) begin : g_pend
            assign pending = |vld_p[RD_LAT-2:0];
        end else begin : g_nopend
            assign pending = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR compute stage: stores each sample in the circular X RAM, walks all taps, outputs y[n].
// Build option FIR_OUT_SAT_EN: clamp the output to OUT_W bits and flag it on m_sat (otherwise wrap).
module fir_tap_sequencer #(
    parameter int RAM_WIDTH   = 8,
    parameter int ORDER       = 8,
    parameter int X_RAM_DEPTH = 8,
    parameter int RD_LAT      = 2,
    parameter int OUT_W       = fir_pkg::OUT_W,
    parameter int FRAC_BITS   = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [RAM_WIDTH-1:0]                    s_data,
    output logic                                    x_we,
    output logic [fir_pkg::clogb2(X_RAM_DEPTH)-1:0] x_waddr,
    output logic [RAM_WIDTH-1:0]                    x_wdata,
    output logic [fir_pkg::clogb2(X_RAM_DEPTH)-1:0] x_raddr,
    input  logic [RAM_WIDTH-1:0]                    x_rdata,
    output logic [fir_pkg::clogb2(ORDER)-1:0]       h_raddr,
    input  logic [RAM_WIDTH-1:0]                    h_rdata,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [OUT_W-1:0]                        m_data,
    output logic                                    m_sat,
    output logic                                    busy
);

    localparam int AW    = fir_pkg::clogb2(X_RAM_DEPTH);
    localparam int HW    = fir_pkg::clogb2(ORDER);
    localparam int ACC_W = 2 * RAM_WIDTH + HW;

    import fir_pkg::*;

    seq_state_t                   state, state_next;
    logic [AW-1:0]                cnt;
    logic [AW-1:0]                wr_ptr;
    logic signed [RAM_WIDTH-1:0]  sample;
    logic                         init_arm;
    logic                         mac_clr;
    logic                         mac_issue;
    logic                         mac_pending;
    logic                         drain_done;
    logic signed [ACC_W-1:0]      acc_next;
    logic [OUT_W:0]               shaped;

`ifdef FIR_OUT_SAT_EN
    function automatic logic [OUT_W:0] shape_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] v;
        longint vl, hi, lo;
        v  = a >>> FRAC_BITS;
        vl = longint'(v);
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        if (vl > hi) return {1'b1, OUT_W'(hi)};
        if (vl < lo) return {1'b1, OUT_W'(lo)};
        return {1'b0, OUT_W'(vl)};
    endfunction
`else
    function automatic logic [OUT_W:0] shape_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] v;
        v = a >>> FRAC_BITS;
        return {1'b0, OUT_W'(v)};
    endfunction
`endif

    assign shaped = shape_out(acc_next);
    // busy stays low while reset is held and for the single settle cycle after it.
    assign busy   = init_arm && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        x_we       = 1'b0;
        x_waddr    = '0;
        x_wdata    = '0;
        x_raddr    = '0;
        h_raddr    = '0;
        mac_clr    = 1'b0;
        mac_issue  = 1'b0;
        drain_done = 1'b0;
        case (state)
            INIT: begin
                x_we    = init_arm;
                x_waddr = cnt;
                if (init_arm && cnt == AW'(X_RAM_DEPTH - 1))
                    state_next = IDLE;
            end
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid)
                    state_next = WRITE;
            end
            WRITE: begin
                x_we       = 1'b1;
                x_waddr    = wr_ptr;
                x_wdata    = sample;
                mac_clr    = 1'b1;
                state_next = READ;
            end
            READ: begin
                x_raddr   = wr_ptr - cnt;
                h_raddr   = HW'(cnt);
                mac_issue = 1'b1;
                if (cnt == AW'(ORDER - 1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                // Exit while the final product is landing; acc_next already includes it.
                if (!mac_pending) begin
                    drain_done = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (m_ready)
                    state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            sample   <= '0;
            init_arm <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_sat    <= 1'b0;
        end else begin
            init_arm <= 1'b1;
            if ((state == INIT && init_arm) || state == READ)
                cnt <= (state_next == state) ? cnt + 1'b1 : '0;
            else
                cnt <= '0;
            if (state == IDLE && s_valid)
                sample <= s_data;
            if (drain_done) begin
                wr_ptr  <= wr_ptr + 1'b1;
                m_valid <= 1'b1;
                m_data  <= shaped[OUT_W-1:0];
                m_sat   <= shaped[OUT_W];
            end else if (state == OUT && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    fir_mac #(
        .RAM_WIDTH (RAM_WIDTH),
        .RD_LAT    (RD_LAT),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (mac_clr),
        .issue    (mac_issue),
        .x_data   (x_rdata),
        .h_data   (h_rdata),
        .acc_next (acc_next),
        .pending  (mac_pending)
    );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: RAM models with 2-cycle reads, convolution model feeding a scoreboard queue.
module tb_fir_tap_sequencer;

    typedef struct {
        logic [15:0] d;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        x_we;
    logic [2:0]  x_waddr;
    logic [7:0]  x_wdata;
    logic [2:0]  x_raddr;
    logic [7:0]  x_rdata;
    logic [2:0]  h_raddr;
    logic [7:0]  h_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_sat;
    logic        busy;

    logic [7:0]  xmem [8];
    logic [7:0]  hmem [8];
    logic [7:0]  x_q1, h_q1;
    logic        prefill;

    int          hist [8];
    int          hcoef [8];
    int          wp;
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] last_data;
    logic        last_sat;

    always #5 clk = ~clk;

    fir_tap_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .x_we    (x_we),
        .x_waddr (x_waddr),
        .x_wdata (x_wdata),
        .x_raddr (x_raddr),
        .x_rdata (x_rdata),
        .h_raddr (h_raddr),
        .h_rdata (h_rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sat   (m_sat),
        .busy    (busy)
    );

    // Both RAMs: address in cycle c, data valid in cycle c+2.
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 8; i++) xmem[i] <= 8'h55;
        end else if (x_we) begin
            xmem[x_waddr] <= x_wdata;
        end
        x_q1    <= xmem[x_raddr];
        x_rdata <= x_q1;
        h_q1    <= hmem[h_raddr];
        h_rdata <= h_q1;
    end

    function automatic exp_t shape(input longint acc);
        exp_t        e;
        logic [63:0] t;
        t = acc;
`ifdef FIR_OUT_SAT_EN
        if (acc > 32767) begin
            e.d = 16'h7fff; e.s = 1'b1;
        end else if (acc < -32768) begin
            e.d = 16'h8000; e.s = 1'b1;
        end else begin
            e.d = t[15:0];  e.s = 1'b0;
        end
`else
        e.d = t[15:0];
        e.s = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) hist[i] = 0;
        wp = 0;
        sb.delete();
    endtask

    task automatic model_push(input int s);
        longint acc;
        hist[wp] = s;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(hcoef[k]) * longint'(hist[(wp - k) & 7]);
        wp = (wp + 1) & 7;
        sb.push_back(shape(acc));
    endtask

    task automatic set_h(input int idx, input int v);
        hcoef[idx] = v;
        hmem[idx]  = 8'(v);
    endtask

    task automatic send(input int s);
        int waited;
        waited = 0;
        while (!s_ready && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_ready) begin
            n_checks++;
            $display("FAIL s_ready_timeout: s_ready=%0b after %0d cycles, want 1", s_ready, waited);
            return;
        end
        s_valid = 1'b1;
        s_data  = 8'(s);
        model_push(s);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic collect(input int hold, input bit chk_lat);
        int          lat;
        logic [15:0] d0;
        exp_t        e;
        lat = 0;
        while (!m_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!m_valid) begin
            n_checks++;
            $display("FAIL m_valid_timeout: m_valid=0 after %0d cycles, want 1", lat);
            return;
        end
        if (chk_lat) begin
            n_checks++;
            if (lat + 1 !== 12) $display("FAIL latency: got %0d cycles, want 12", lat + 1);
            else n_pass++;
        end
        d0 = m_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({m_valid, m_data, s_ready} !== {1'b1, d0, 1'b0})
                $display("FAIL backpressure_hold: got v=%0b d=%h rdy=%0b, want v=1 d=%h rdy=0",
                         m_valid, m_data, s_ready, d0);
            else n_pass++;
        end
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got output %h, want none", m_data);
        end else begin
            e = sb.pop_front();
            if ({m_data, m_sat} !== {e.d, e.s})
                $display("FAIL output: got d=%0d sat=%0b, want d=%0d sat=%0b",
                         $signed(m_data), m_sat, $signed(e.d), e.s);
            else n_pass++;
        end
        last_data = m_data;
        last_sat  = m_sat;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        n_checks++;
        if ({m_valid, s_ready} !== 2'b01)
            $display("FAIL after_handshake: got v=%0b rdy=%0b, want v=0 rdy=1", m_valid, s_ready);
        else n_pass++;
    endtask

    task automatic run(input int s, input int hold, input bit chk_lat);
        send(s);
        collect(hold, chk_lat);
    endtask

    task automatic check_init();
        int idx;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (m_valid) begin
                n_checks++;
                $display("FAIL stale_m_valid: got 1, want 0 during INIT");
            end
            if (x_we) begin
                n_checks++;
                if ({x_waddr, x_wdata, s_ready} !== {3'(idx), 8'h00, 1'b0})
                    $display("FAIL init_write: got a=%0d d=%h rdy=%0b, want a=%0d d=00 rdy=0",
                             x_waddr, x_wdata, s_ready, idx);
                else n_pass++;
                idx++;
            end else if (s_ready) begin
                break;
            end
        end
        n_checks++;
        if (idx !== 8 || s_ready !== 1'b1)
            $display("FAIL init_done: got writes=%0d rdy=%0b, want writes=8 rdy=1", idx, s_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        prefill = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        prefill = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, x_we, x_waddr, x_wdata, x_raddr, h_raddr, m_valid, m_data, m_sat, busy} !== '0)
            $display("FAIL reset_outputs: got rdy=%0b we=%0b wa=%0d wd=%h ra=%0d ha=%0d v=%0b d=%h sat=%0b busy=%0b, want all 0",
                     s_ready, x_we, x_waddr, x_wdata, x_raddr, h_raddr, m_valid, m_data, m_sat, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_init();
    endtask

    task automatic test_impulse();
        for (int k = 0; k < 8; k++) set_h(k, k + 1);
        run(1, 0, 1'b0);
        for (int i = 0; i < 11; i++) run(0, 0, 1'b0);
    endtask

    task automatic test_latency_backpressure();
        for (int k = 0; k < 8; k++) set_h(k, 3 - k);
        run(5, 5, 1'b1);
        run(-7, 2, 1'b1);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 8; k++) set_h(k, 127);
        for (int i = 0; i < 8; i++) run(127, 0, 1'b0);
        n_checks++;
`ifdef FIR_OUT_SAT_EN
        if ({last_data, last_sat} !== {16'h7fff, 1'b1})
            $display("FAIL sat_pos: got d=%0d sat=%0b, want d=32767 sat=1", $signed(last_data), last_sat);
        else n_pass++;
`else
        if ({last_data, last_sat} !== {16'hf808, 1'b0})
            $display("FAIL wrap_pos: got d=%0d sat=%0b, want d=-2040 sat=0", $signed(last_data), last_sat);
        else n_pass++;
`endif
    endtask

    task automatic test_negative();
        for (int k = 0; k < 8; k++) set_h(k, -128);
        for (int i = 0; i < 8; i++) run(-128, 0, 1'b0);
        n_checks++;
`ifdef FIR_OUT_SAT_EN
        if ({last_data, last_sat} !== {16'h7fff, 1'b1})
            $display("FAIL sat_neg_extreme: got d=%0d sat=%0b, want d=32767 sat=1", $signed(last_data), last_sat);
        else n_pass++;
`else
        if ({last_data, last_sat} !== {16'h0000, 1'b0})
            $display("FAIL wrap_neg_extreme: got d=%0d sat=%0b, want d=0 sat=0", $signed(last_data), last_sat);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_read();
        for (int k = 0; k < 8; k++) set_h(k, k + 1);
        send(1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, busy, s_ready} !== 3'b000)
            $display("FAIL midread_reset: got v=%0b busy=%0b rdy=%0b, want 0 0 0", m_valid, busy, s_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_init();
        run(1, 0, 1'b0);
        run(0, 0, 1'b0);
        run(0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) set_h(k, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 10; i++) run(int'($urandom_range(0, 255)) - 128, 0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        prefill = 1'b0;
        for (int k = 0; k < 8; k++) set_h(k, 0);
        model_reset();
        test_reset();
        test_impulse();
        test_latency_backpressure();
        test_saturation();
        test_negative();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
